seg_scan: RTL and testbench

//  Multi-digit display scanner, upstream of the 7-segment decoder. Holds a packed
//  4-bit-per-digit display value and time-multiplexes one digit at a time onto num.
//  num feeds the decoder's num input. dig_sel drives the active-low digit commons.

---
 rtl/seg_scan.sv | 64 ++++++
 tb/tb_seg_scan.sv | 137 +++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// seg_scan: multiplexed digit scanner with dead time, leading-zero blanking and frame-aligned updates
module seg_scan #(
    parameter int DIGITS    = 4,
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  lz_en,
    output logic [3:0]            num,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);
    localparam int CW = $clog2(DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DIV - 1);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);
    logic [CW-1:0] cnt, cnt_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [4*DIGITS-1:0] shadow, shadow_nx, pending;
    logic pend, wrap, last, lead;
    logic [DIGITS-1:0] blank;
    assign wrap      = cnt == CMAX;
    assign last      = wrap && idx == IMAX;
    assign cnt_nx    = wrap ? '0 : cnt + 1'b1;
    assign idx_nx    = !wrap ? idx : (idx == IMAX ? '0 : idx + 1'b1);
    assign shadow_nx = !last ? shadow : load ? din : pend ? pending : shadow;
    // outputs are derived from the post-edge state so they carry no extra lag
    always_comb begin
        blank = '0;
        lead  = lz_en;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lead     = lead && shadow_nx[4*i +: 4] == 4'd0;
            blank[i] = lead;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            idx        <= '0;
            shadow     <= '0;
            pending    <= '0;
            pend       <= 1'b0;
            num        <= 4'd0;
            dig_sel    <= '1;
            frame_done <= 1'b0;
        end else begin
            cnt    <= cnt_nx;
            idx    <= idx_nx;
            shadow <= shadow_nx;
            if (last)
                pend <= 1'b0;
            else if (load) begin
                pending <= din;
                pend    <= 1'b1;
            end
            num        <= shadow_nx[{idx_nx, 2'b00} +: 4];
            dig_sel    <= (cnt_nx < CW'(BLANK_CYC) || blank[idx_nx]) ? '1 : ~(DIGITS'(1) << idx_nx);
            frame_done <= cnt_nx == CMAX && idx_nx == IMAX;
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: scoreboard bench for seg_scan (DIGITS=4, DIV=8, BLANK_CYC=2)
module tb_seg_scan;
    localparam int DIGITS = 4, DIV = 8, BLANK = 2, FR = DIGITS * DIV;
    logic clk = 1'b0, rst_n = 1'b0, load = 1'b0, lz_en = 1'b0;
    logic [15:0] din = '0;
    logic [3:0] num, dig_sel;
    logic frame_done;
    typedef struct { logic [3:0] num; logic [3:0] sel; logic fd; } exp_t;
    exp_t q[$];
    int checks = 0, failures = 0;
    int m_t = 0, ncyc = 0, last_fd = -1;
    logic [15:0] m_shadow = '0, m_pending = '0;
    logic m_pend = 1'b0;

    seg_scan #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din), .lz_en(lz_en),
        .num(num), .dig_sel(dig_sel), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, m_t);
        end
    endtask

    // model: time since reset determines slot position; shadow swaps at frame edges
    task automatic step();
        exp_t e;
        int c, d;
        logic [15:0] up;
        if (!rst_n) begin
            m_t = 0; m_shadow = '0; m_pending = '0; m_pend = 1'b0;
        end else begin
            if (m_t % FR == FR - 1) begin
                m_shadow = load ? din : (m_pend ? m_pending : m_shadow);
                m_pend = 1'b0;
            end else if (load) begin
                m_pending = din; m_pend = 1'b1;
            end
            m_t++;
        end
        c = m_t % DIV;
        d = (m_t / DIV) % DIGITS;
        up = m_shadow >> (4 * d);
        e.num = up[3:0];
        e.sel = (c < BLANK || (lz_en && d != 0 && up == 16'd0)) ? 4'hF : ~(4'b1 << d);
        e.fd  = (m_t % FR) == FR - 1;
        q.push_back(e);
        @(posedge clk);
        #1;
        ncyc++;
        e = q.pop_front();
        chk("num", {28'd0, num}, {28'd0, e.num});
        chk("dig_sel", {28'd0, dig_sel}, {28'd0, e.sel});
        chk("frame_done", {31'd0, frame_done}, {31'd0, e.fd});
        if (!rst_n) last_fd = -1;
        else if (frame_done) begin
            if (last_fd >= 0) chk("fd_period", ncyc - last_fd, FR);
            last_fd = ncyc;
        end
    endtask

    task automatic run_to(input int pos);
        int b = 0;
        while ((m_t % FR) != pos && b < 100) begin
            step();
            b++;
        end
        if (b >= 100) chk("run_to_timeout", b, 0);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_num", {28'd0, num}, 0);
        chk("rst_sel", {28'd0, dig_sel}, 32'hF);
        chk("rst_fd", {31'd0, frame_done}, 0);
        rst_n = 1'b1;
        step();
        chk("dead1_sel", {28'd0, dig_sel}, 32'hF);
        step();
        chk("lit_sel", {28'd0, dig_sel}, 32'hE);
        // mid-frame load must not appear until the next frame
        run_to(3);
        load = 1'b1; din = 16'h1234;
        step();
        load = 1'b0;
        run_to(10); chk("old_num", {28'd0, num}, 0);
        run_to(2);  chk("f_num0", {28'd0, num}, 4); chk("f_sel0", {28'd0, dig_sel}, 32'hE);
        run_to(10); chk("f_num1", {28'd0, num}, 3); chk("f_sel1", {28'd0, dig_sel}, 32'hD);
        run_to(18); chk("f_num2", {28'd0, num}, 2); chk("f_sel2", {28'd0, dig_sel}, 32'hB);
        run_to(26); chk("f_num3", {28'd0, num}, 1); chk("f_sel3", {28'd0, dig_sel}, 32'h7);
        lz_en = 1'b1; load = 1'b1; din = 16'h0070;
        step();
        load = 1'b0;
        run_to(2);  chk("lz_num0", {28'd0, num}, 0); chk("lz_sel0", {28'd0, dig_sel}, 32'hE);
        run_to(10); chk("lz_num1", {28'd0, num}, 7); chk("lz_sel1", {28'd0, dig_sel}, 32'hD);
        run_to(18); chk("lz_sel2", {28'd0, dig_sel}, 32'hF);
        run_to(26); chk("lz_sel3", {28'd0, dig_sel}, 32'hF);
        load = 1'b1; din = 16'h000A;
        step();
        load = 1'b0;
        run_to(2);  chk("a_num0", {28'd0, num}, 32'hA); chk("a_sel0", {28'd0, dig_sel}, 32'hE);
        run_to(10); chk("a_sel1_blank", {28'd0, dig_sel}, 32'hF);
        run_to(12);
        lz_en = 1'b0;
        step();
        chk("lz_off_sel", {28'd0, dig_sel}, 32'hD); chk("lz_off_num", {28'd0, num}, 0);
        // load on a frame_done cycle bypasses pending
        run_to(31);
        chk("fd_pulse", {31'd0, frame_done}, 1);
        load = 1'b1; din = 16'h5678;
        step();
        load = 1'b0;
        chk("direct_num", {28'd0, num}, 8);
        repeat (FR) step();
        run_to(16);
        load = 1'b1; din = 16'h9999;
        step();
        load = 1'b0;
        run_to(24);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rst2_num", {28'd0, num}, 0);
        chk("rst2_sel", {28'd0, dig_sel}, 32'hF);
        repeat (2 * FR) begin
            step();
            chk("no_nine", {31'd0, num == 4'd9}, 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
